wb_merge: RTL and testbench

Write-back merge stage sitting directly upstream of the register file's single write port. It combines the in-order pipeline write-back (from the MEM/WB register) with results returned by long-latency units (divider, late load return) over a valid/ready channel. Deferred results wait in a small FIFO until a cycle without a pipeline write. A lookup port lets the decode stage detect and forward pending deferred results that the register file cannot yet see.

---
 rtl/wb_merge_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 90 +++++++++
 rtl/wb_merge.sv | 107 ++++++++++
 tb/tb_wb_merge.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_merge_pkg.sv
// Shared register-file widths, write-enable encodings and the deferred-result entry type.
package wb_merge_pkg;

  localparam int          RegNumLog2   = 5;
  localparam int          RegW         = 32;
  localparam int          WbFifoDepth  = 2;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0;

  typedef logic [RegW-1:0]       reg_word_t;
  typedef logic [RegNumLog2-1:0] reg_addr_t;

  typedef struct packed {
    logic      vld;
    reg_addr_t addr;
    reg_word_t dat;
  } wb_entry_t;

  // Register 0 is hard-wired, so it never matches a pending write.
  function automatic logic addr_hit(input reg_addr_t q, input reg_addr_t a);
    return (q != '0) && (q == a);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of deferred write-backs with same-address kill and youngest-match lookup.
// Push/pop take effect at the clock edge; the caller guarantees no push when full and no pop when empty.
module wb_fifo
  import wb_merge_pkg::*;
#(
  parameter int  DEPTH = WbFifoDepth,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  reg_addr_t     push_addr_i,
  input  reg_word_t     push_data_i,
  input  logic          pop_i,
  input  logic          kill_i,
  input  reg_addr_t     kill_addr_i,
  input  reg_addr_t     raddr1_i,
  input  reg_addr_t     raddr2_i,
  output logic          busy1_o,
  output logic          busy2_o,
  output reg_word_t     fwd1_o,
  output reg_word_t     fwd2_o,
  output logic          head_vld_o,
  output reg_addr_t     head_addr_o,
  output reg_word_t     head_data_o,
  output logic [PW:0]   count_o
);

  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  logic [PW-1:0]   idx;

  // Kill is applied last so it also catches an entry written in the same edge.
  always_comb begin
    mem_d = mem_q;
    if (pop_i) mem_d[rd_ptr_q].vld = 1'b0;
    if (push_i) begin
      mem_d[wr_ptr_q].vld  = 1'b1;
      mem_d[wr_ptr_q].addr = push_addr_i;
      mem_d[wr_ptr_q].dat  = push_data_i;
    end
    if (kill_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_d[i].addr == kill_addr_i) mem_d[i].vld = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_q + PW'(push_i);
      rd_ptr_q <= rd_ptr_q + PW'(pop_i);
      count_q  <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    busy1_o = 1'b0;
    busy2_o = 1'b0;
    fwd1_o  = ZeroWord;
    fwd2_o  = ZeroWord;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (mem_q[idx].vld && addr_hit(raddr1_i, mem_q[idx].addr)) begin
        busy1_o = 1'b1;
        fwd1_o  = mem_q[idx].dat;
      end
      if (mem_q[idx].vld && addr_hit(raddr2_i, mem_q[idx].addr)) begin
        busy2_o = 1'b1;
        fwd2_o  = mem_q[idx].dat;
      end
    end
  end

  assign head_vld_o  = mem_q[rd_ptr_q].vld;
  assign head_addr_o = mem_q[rd_ptr_q].addr;
  assign head_data_o = mem_q[rd_ptr_q].dat;
  assign count_o     = count_q;

endmodule

// File: rtl/wb_merge.sv
// Merges pipeline write-back (priority, 1 cycle) with deferred long-latency results into one regfile port.
// Port B is back-pressured only by FIFO occupancy; port A is never stalled.
module wb_merge
  import wb_merge_pkg::*;
#(
  parameter int DEPTH = WbFifoDepth
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      a_we,
  input  reg_addr_t a_waddr,
  input  reg_word_t a_wdata,
  input  logic      b_valid,
  output logic      b_ready,
  input  reg_addr_t b_waddr,
  input  reg_word_t b_wdata,
  input  reg_addr_t raddr1,
  input  reg_addr_t raddr2,
  output logic      busy1,
  output logic      busy2,
  output reg_word_t fwd1,
  output reg_word_t fwd2,
  output logic      we,
  output reg_addr_t waddr,
  output reg_word_t wdata
);

  localparam int PW = $clog2(DEPTH);

  logic        a_wr, b_keep, fifo_empty, pop, push, bypass;
  logic        head_vld;
  reg_addr_t   head_addr;
  reg_word_t   head_data;
  logic [PW:0] count;

  logic        we_q, we_d;
  reg_addr_t   waddr_q, waddr_d;
  reg_word_t   wdata_q, wdata_d;

  assign a_wr       = (a_we == WriteEnable) && (a_waddr != '0);
  assign b_ready    = rst && (count < (PW+1)'(DEPTH));
  assign b_keep     = b_valid && b_ready && (b_waddr != '0);
  assign fifo_empty = (count == '0);
  assign pop        = !a_wr && !fifo_empty;
  assign bypass     = !a_wr && fifo_empty && b_keep;
  assign push       = b_keep && !bypass;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_addr_i (b_waddr),
    .push_data_i (b_wdata),
    .pop_i       (pop),
    .kill_i      (a_wr),
    .kill_addr_i (a_waddr),
    .raddr1_i    (raddr1),
    .raddr2_i    (raddr2),
    .busy1_o     (busy1),
    .busy2_o     (busy2),
    .fwd1_o      (fwd1),
    .fwd2_o      (fwd2),
    .head_vld_o  (head_vld),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (count)
  );

  // A killed head is still popped, but produces an idle cycle.
  always_comb begin
    we_d    = WriteDisable;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (a_wr) begin
      we_d    = WriteEnable;
      waddr_d = a_waddr;
      wdata_d = a_wdata;
    end else if (pop) begin
      if (head_vld) begin
        we_d    = WriteEnable;
        waddr_d = head_addr;
        wdata_d = head_data;
      end
    end else if (bypass) begin
      we_d    = WriteEnable;
      waddr_d = b_waddr;
      wdata_d = b_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= WriteDisable;
      waddr_q <= '0;
      wdata_q <= ZeroWord;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_wb_merge.sv
// Scoreboard bench for wb_merge: a behavioural model queues expected regfile writes as stimulus is applied.
module tb_wb_merge;
  import wb_merge_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_we, b_valid, b_ready;
  logic [4:0]  a_waddr, b_waddr, raddr1, raddr2, waddr;
  logic [31:0] a_wdata, b_wdata, fwd1, fwd2, wdata;
  logic        busy1, busy2, we;

  always #5 clk = ~clk;

  wb_merge #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .busy1(busy1), .busy2(busy2), .fwd1(fwd1), .fwd2(fwd2),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  typedef struct { bit vld; logic [4:0] addr; logic [31:0] dat; } ment_t;
  typedef struct { logic [4:0] addr; logic [31:0] dat; } wr_t;

  ment_t       m_q[$];
  wr_t         exp_q[$];
  bit          m_we;
  logic [31:0] shadow [32];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] m_lookup(input logic [4:0] ra);
    logic [32:0] r;
    r = 33'h0;
    foreach (m_q[i]) if (ra != 0 && m_q[i].vld && m_q[i].addr == ra) r = {1'b1, m_q[i].dat};
    return r;
  endfunction

  task automatic drv(input bit awe, input logic [4:0] aa, input logic [31:0] ad,
                     input bit bv, input logic [4:0] ba, input logic [31:0] bd);
    a_we = awe; a_waddr = aa; a_wdata = ad;
    b_valid = bv; b_waddr = ba; b_wdata = bd;
  endtask

  // One clock: check pre-edge combinational outputs, advance the model, check the registered write.
  task automatic step();
    logic [32:0] l1, l2;
    bit          a_wr, b_ok, byp;
    ment_t       e;
    wr_t         w;
    if (!rst) begin
      m_q.delete();
      exp_q.delete();
    end
    #1;
    chk("b_ready", b_ready, 32'(rst && m_q.size() < DEPTH));
    l1 = m_lookup(raddr1);
    l2 = m_lookup(raddr2);
    chk("busy1", busy1, 32'(l1[32]));
    chk("fwd1", fwd1, l1[31:0]);
    chk("busy2", busy2, 32'(l2[32]));
    chk("fwd2", fwd2, l2[31:0]);
    @(posedge clk);
    m_we = 1'b0;
    if (rst) begin
      a_wr = a_we && a_waddr != 0;
      b_ok = b_valid && m_q.size() < DEPTH && b_waddr != 0;
      byp  = 1'b0;
      if (a_wr) begin
        m_we = 1'b1;
        w.addr = a_waddr; w.dat = a_wdata; exp_q.push_back(w);
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        if (e.vld) begin
          m_we = 1'b1;
          w.addr = e.addr; w.dat = e.dat; exp_q.push_back(w);
        end
      end else if (b_ok) begin
        m_we = 1'b1; byp = 1'b1;
        w.addr = b_waddr; w.dat = b_wdata; exp_q.push_back(w);
      end
      if (b_ok && !byp) begin
        e.vld = 1'b1; e.addr = b_waddr; e.dat = b_wdata; m_q.push_back(e);
      end
      if (a_wr) foreach (m_q[i]) if (m_q[i].addr == a_waddr) m_q[i].vld = 1'b0;
    end
    #1;
    chk("we", we, 32'(m_we));
    if (we === 1'b1) begin
      if (exp_q.size() == 0) chk("we_unexpected", we, 0);
      else begin
        w = exp_q.pop_front();
        chk("waddr", waddr, 32'(w.addr));
        chk("wdata", wdata, w.dat);
        shadow[waddr] = wdata;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    foreach (shadow[i]) shadow[i] = 32'h0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      drv(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
      raddr1 = 5'($urandom); raddr2 = 5'($urandom);
      step();
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_busy1", busy1, 0);
      chk("rst_fwd1", fwd1, 0);
    end
    rst = 1'b1;
    raddr1 = 5'd0; raddr2 = 5'd0;
    drv(0, 0, 0, 0, 0, 0);
    step();

    // Port A then B in the same edge; r4 is pending during the A write-back cycle.
    drv(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    raddr1 = 5'd4;
    step();
    chk("a_then_b_busy_r4", busy1, 1);
    drv(0, 0, 0, 0, 0, 0);
    step();
    step();

    // Fill and back-pressure: A busy every cycle, B offers r5 then r6.
    for (int i = 0; i < 4; i++) begin
      drv(1, 5'(10 + i), 32'(100 + i), i < 2, (i == 0) ? 5'd5 : 5'd6, (i == 0) ? 32'h55 : 32'h66);
      step();
    end
    #1 chk("full_b_ready", b_ready, 0);
    drv(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    chk("drained_b_ready", b_ready, 1);

    // Forwarding picks the youngest of two r7 entries.
    drv(1, 5'd20, 32'h20, 1, 5'd7, 32'hA); step();
    drv(1, 5'd21, 32'h21, 1, 5'd7, 32'hB); step();
    drv(1, 5'd22, 32'h22, 0, 0, 0);
    raddr1 = 5'd7;
    #1;
    chk("fwd_busy1", busy1, 1);
    chk("fwd_data1", fwd1, 32'hB);
    step();
    drv(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    raddr1 = 5'd0;

    // WAW kill: later port A write to r8 supersedes the queued r8.
    drv(1, 5'd9, 32'h5, 1, 5'd8, 32'h1); step();
    raddr2 = 5'd8;
    #1 chk("waw_busy_before", busy2, 1);
    drv(1, 5'd8, 32'h9, 0, 0, 0); step();
    chk("waw_busy_after", busy2, 0);
    drv(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    chk("waw_final_r8", shadow[8], 32'h9);
    raddr2 = 5'd0;

    // Register 0 from port B is accepted and dropped.
    drv(0, 0, 0, 1, 5'd0, 32'hFFFF); step();
    chk("zero_b_ready", b_ready, 1);
    drv(0, 0, 0, 0, 0, 0); step();

    // Random traffic with a reset in the middle.
    for (int i = 0; i < 300; i++) begin
      rst = !(i == 150 || i == 151);
      drv($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
          1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      raddr1 = 5'($urandom_range(0, 7));
      raddr2 = 5'($urandom_range(0, 7));
      step();
    end
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    chk("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
